option_price_sched: RTL

Round-robin scheduler that shares one Black-Scholes pricing engine between NREQ requesters.
- Each requester presents a Q16.16 operand bundle with a valid/ready handshake.
- The scheduler latches the granted bundle and drives the engine with a one-cycle start pulse.
- It waits for the engine's done pulse, then returns the price tagged with the requester ID.
- It sits between the per-channel CND front ends and the shared option-price engine.

---
 rtl/option_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/option_price_sched.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/option_pkg.sv
// Shared types and constants for the option-pricing datapath.
// Q16.16 fixed point, scheduler state encoding and the operand bundle layout
// that the engine wrapper also uses.
package option_pkg;

  localparam int          FRAC_BITS = 16;
  localparam logic [31:0] ONE_Q     = 32'h0001_0000;
  localparam int          OPW       = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [OPW-1:0] rate;
    logic [OPW-1:0] timetm;
    logic [OPW-1:0] spot;
    logic [OPW-1:0] strike;
    logic [OPW-1:0] nd1;
    logic [OPW-1:0] nd2;
    logic           otype;
  } opnd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or after ptr_i,
// wrapping modulo NREQ. Purely combinational; grant is all-zero when en_i is low.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o
);

  logic [IDW-1:0] cand;
  logic           found;

  // Scan from the pointer position and pick the first asserted request.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr_i) + k) % NREQ);
      if (en_i && !found && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/option_price_sched.sv
// Round-robin scheduler sharing one Black-Scholes engine between NREQ requesters.
// One job in flight: IDLE (grant/latch) -> ISSUE (start pulse) -> WAIT (engine)
// -> RESP (hold tagged price until accepted).
// Optional watchdog on the WAIT state enabled by macro PRICE_TIMEOUT_EN.
module option_price_sched
  import option_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int NREQ           = 4,
  parameter int IDW            = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_rate,
  input  logic [NREQ*WIDTH-1:0] req_timetm,
  input  logic [NREQ*WIDTH-1:0] req_spot,
  input  logic [NREQ*WIDTH-1:0] req_strike,
  input  logic [NREQ*WIDTH-1:0] req_nd1,
  input  logic [NREQ*WIDTH-1:0] req_nd2,
  input  logic [NREQ-1:0]       req_otype,
  output logic                  eng_start,
  output logic [WIDTH-1:0]      eng_rate,
  output logic [WIDTH-1:0]      eng_timetm,
  output logic [WIDTH-1:0]      eng_spot,
  output logic [WIDTH-1:0]      eng_strike,
  output logic [WIDTH-1:0]      eng_nd1,
  output logic [WIDTH-1:0]      eng_nd2,
  output logic                  eng_otype,
  input  logic                  eng_done,
  input  logic [WIDTH-1:0]      eng_price,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_price,
  output logic                  rsp_err,
  output logic                  busy
);

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q;
  logic [IDW-1:0] gnt_idx;
  logic [NREQ-1:0] gnt;
  logic           accept;
  logic           load_op;
  logic           load_rsp;
  logic [WIDTH-1:0] price_d;
  logic [WIDTH-1:0] rate_q, timetm_q, spot_q, strike_q, nd1_q, nd2_q, price_q;
  logic             otype_q;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .en_i  (state_q == IDLE),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign accept    = |gnt;
  assign req_ready = gnt;
  assign eng_start = (state_q == ISSUE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

  assign eng_rate   = rate_q;
  assign eng_timetm = timetm_q;
  assign eng_spot   = spot_q;
  assign eng_strike = strike_q;
  assign eng_nd1    = nd1_q;
  assign eng_nd2    = nd2_q;
  assign eng_otype  = otype_q;
  assign rsp_id     = id_q;
  assign rsp_price  = price_q;

`ifdef PRICE_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  assign rsp_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign rsp_err        = 1'b0;
`endif

  // Next-state, pointer advance and capture strobes for the job sequence.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    load_op  = 1'b0;
    load_rsp = 1'b0;
    price_d  = price_q;
`ifdef PRICE_TIMEOUT_EN
    cnt_d = cnt_q;
    err_d = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          load_op = 1'b1;
          state_d = ISSUE;
          ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef PRICE_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      WAIT: begin
        if (eng_done) begin
          state_d  = RESP;
          price_d  = eng_price;
          load_rsp = 1'b1;
`ifdef PRICE_TIMEOUT_EN
          err_d = 1'b0;
`endif
        end
`ifdef PRICE_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CNTW'(1);
          if (cnt_d == CNTW'(TIMEOUT_CYCLES)) begin
            state_d  = RESP;
            price_d  = '0;
            load_rsp = 1'b1;
            err_d    = 1'b1;
          end
        end
`endif
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
`ifdef PRICE_TIMEOUT_EN
      cnt_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
`ifdef PRICE_TIMEOUT_EN
      cnt_q <= cnt_d;
      err_q <= err_d;
`endif
    end
  end

  // Datapath: latch the granted bundle/ID on accept, the price on completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rate_q   <= '0;
      timetm_q <= '0;
      spot_q   <= '0;
      strike_q <= '0;
      nd1_q    <= '0;
      nd2_q    <= '0;
      otype_q  <= 1'b0;
      id_q     <= '0;
      price_q  <= '0;
    end else begin
      if (load_op) begin
        rate_q   <= req_rate[gnt_idx*WIDTH +: WIDTH];
        timetm_q <= req_timetm[gnt_idx*WIDTH +: WIDTH];
        spot_q   <= req_spot[gnt_idx*WIDTH +: WIDTH];
        strike_q <= req_strike[gnt_idx*WIDTH +: WIDTH];
        nd1_q    <= req_nd1[gnt_idx*WIDTH +: WIDTH];
        nd2_q    <= req_nd2[gnt_idx*WIDTH +: WIDTH];
        otype_q  <= req_otype[gnt_idx];
        id_q     <= gnt_idx;
      end
      if (load_rsp) price_q <= price_d;
    end
  end

endmodule
